axil_arb_2x1: RTL

Two-master, one-slave AXI4-Lite arbiter. It shares a single AXI4-Lite slave, typically the on-chip RAM, between two requesters, such as the core's instruction and data ports. It grants one complete transaction at a time, either a write (AW+W+B) or a read (AR+R), using round-robin between masters. It routes the response back to the granted master only.

---
 rtl/axil_arb_2x1_if.sv | 39 +++
 rtl/axil_arb_2x1.sv | 127 ++++++++++++
 2 files changed

// File: rtl/axil_arb_2x1_if.sv
// rtl/axil_arb_2x1_if.sv - AXI4-Lite bundle for N lanes, lane i in slice [i*W +: W]
interface axil_arb_2x1_if #(
  parameter int N          = 1,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [N*ADDR_WIDTH-1:0] awaddr;
  logic [N*3-1:0]          awprot;
  logic [N-1:0]            awvalid;
  logic [N-1:0]            awready;
  logic [N*DATA_WIDTH-1:0] wdata;
  logic [N*STRB_WIDTH-1:0] wstrb;
  logic [N-1:0]            wvalid;
  logic [N-1:0]            wready;
  logic [N*2-1:0]          bresp;
  logic [N-1:0]            bvalid;
  logic [N-1:0]            bready;
  logic [N*ADDR_WIDTH-1:0] araddr;
  logic [N*3-1:0]          arprot;
  logic [N-1:0]            arvalid;
  logic [N-1:0]            arready;
  logic [N*DATA_WIDTH-1:0] rdata;
  logic [N*2-1:0]          rresp;
  logic [N-1:0]            rvalid;
  logic [N-1:0]            rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_arb_2x1.sv
// rtl/axil_arb_2x1.sv - two-master, one-slave AXI4-Lite round-robin arbiter
// One whole write (AW+W+B) or read (AR+R) is granted at a time.
module axil_arb_2x1 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic           clk,
  input  logic           rst,
  axil_arb_2x1_if.slave  s_axil,
  axil_arb_2x1_if.master m_axil
);

  typedef enum logic [1:0] {IDLE, WR, WB, RD} state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        ar_done_q, ar_done_d;
  logic [1:0]  wreq, rreq, req;
  int unsigned gi;

  assign wreq = s_axil.awvalid & s_axil.wvalid;
  assign rreq = s_axil.arvalid;
  assign req  = wreq | rreq;
  assign gi   = {31'd0, gnt_q};

  // Payload always follows the registered grant; valids decide when it matters.
  assign m_axil.awaddr = s_axil.awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_axil.awprot = s_axil.awprot[gi*3 +: 3];
  assign m_axil.wdata  = s_axil.wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  assign m_axil.wstrb  = s_axil.wstrb[gi*STRB_WIDTH +: STRB_WIDTH];
  assign m_axil.araddr = s_axil.araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_axil.arprot = s_axil.arprot[gi*3 +: 3];

  assign s_axil.bresp = {2{m_axil.bresp}};
  assign s_axil.rdata = {2{m_axil.rdata}};
  assign s_axil.rresp = {2{m_axil.rresp}};

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ar_done_d = ar_done_q;

    m_axil.awvalid = 1'b0;
    m_axil.wvalid  = 1'b0;
    m_axil.bready  = 1'b0;
    m_axil.arvalid = 1'b0;
    m_axil.rready  = 1'b0;
    s_axil.awready = '0;
    s_axil.wready  = '0;
    s_axil.bvalid  = '0;
    s_axil.arready = '0;
    s_axil.rvalid  = '0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d     = (&req) ? ~last_q : req[1];
          state_d   = wreq[gnt_d] ? WR : RD;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          ar_done_d = 1'b0;
        end
      end
      WR: begin
        // AW and W complete independently; each is dropped once accepted.
        m_axil.awvalid        = ~aw_done_q;
        m_axil.wvalid         = ~w_done_q;
        s_axil.awready[gnt_q] = m_axil.awready & ~aw_done_q;
        s_axil.wready[gnt_q]  = m_axil.wready & ~w_done_q;
        aw_done_d = aw_done_q | m_axil.awready;
        w_done_d  = w_done_q | m_axil.wready;
        if (aw_done_d && w_done_d) begin
          state_d = WB;
        end
      end
      WB: begin
        m_axil.bready        = s_axil.bready[gnt_q];
        s_axil.bvalid[gnt_q] = m_axil.bvalid;
        if (m_axil.bvalid && s_axil.bready[gnt_q]) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      RD: begin
        if (!ar_done_q) begin
          m_axil.arvalid        = 1'b1;
          s_axil.arready[gnt_q] = m_axil.arready;
          ar_done_d             = m_axil.arready;
        end else begin
          m_axil.rready        = s_axil.rready[gnt_q];
          s_axil.rvalid[gnt_q] = m_axil.rvalid;
          if (m_axil.rvalid && s_axil.rready[gnt_q]) begin
            last_d  = gnt_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ar_done_q <= ar_done_d;
    end
  end

endmodule
